// File: rtl/control_azar_pkg.sv
// Shared types and the fixed stimulus sequence for the control_azar hazard checker.
package control_azar_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam int SEQ_LEN = 7;

   // {a,b} per step, step 0 in the low bits: 00, 01, 11, 01, 00, 10, 00
   localparam logic [2*SEQ_LEN-1:0] SEQ = {2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00};

   function automatic logic [1:0] seq_at(input logic [2:0] i);
      return SEQ[{i, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/control_azar_sincronizador_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops clear to 0 on reset.
module sincronizador_2ff (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/control_azar.sv
// Drives a fixed {a,b} sequence into a 2-input UUT, counts f transitions per settle window and
// checks f against a truth table. Define CONTROL_AZAR_SYNC_EN to pass f through a 2-flop synchronizer.
module control_azar
   import control_azar_pkg::*;
#(
   parameter int SETTLE = 8,
   parameter int W      = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [3:0]   tabla,
   output logic         a,
   output logic         b,
   input  logic         f,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] err_count,
   output logic [W-1:0] glitch_count,
   output logic         pass
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [W-1:0] CNT_MAX = '1;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [1:0]    tcnt;
   logic          f_prev;
   logic          f_use;
   logic [3:0]    tabla_q;
   logic [W-1:0]  err_nx, glitch_nx;
   logic          run_req;

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

`ifdef CONTROL_AZAR_SYNC_EN
   sincronizador_2ff u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (f),
      .q       (f_use)
   );
`else
   assign f_use = f;
`endif

   assign run_req = (state == ST_IDLE) && start;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (start) state_nx = ST_APPLY;
         ST_APPLY:  state_nx = ST_SETTLE;
         ST_SETTLE: if (cnt == CW'(SETTLE - 1)) state_nx = ST_SAMPLE;
         ST_SAMPLE: state_nx = (idx == 3'(SEQ_LEN - 1)) ? ST_DONE : ST_APPLY;
         ST_DONE:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Next counts are needed one edge early so pass can rise together with done.
   always_comb begin
      err_nx    = err_count;
      glitch_nx = glitch_count;
      if (run_req) begin
         err_nx    = '0;
         glitch_nx = '0;
      end else if (state == ST_SAMPLE) begin
         if (f_use != tabla_q[{a, b}]) err_nx = sat_inc(err_count);
         if (tcnt > 2'd1)              glitch_nx = sat_inc(glitch_count);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a            <= 1'b0;
         b            <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         err_count    <= '0;
         glitch_count <= '0;
         idx          <= '0;
         tcnt         <= '0;
         cnt          <= '0;
         f_prev       <= 1'b0;
         tabla_q      <= '0;
      end else begin
         err_count    <= err_nx;
         glitch_count <= glitch_nx;
         busy         <= (state_nx == ST_APPLY) || (state_nx == ST_SETTLE) || (state_nx == ST_SAMPLE);
         done         <= (state_nx == ST_DONE);
         if (run_req)
            pass <= 1'b0;
         else if (state_nx == ST_DONE)
            pass <= (err_nx == '0) && (glitch_nx == '0);

         case (state)
            ST_IDLE: begin
               if (start) begin
                  tabla_q <= tabla;
                  idx     <= '0;
               end
            end
            ST_APPLY: begin
               {a, b} <= seq_at(idx);
               f_prev <= f_use;
               tcnt   <= '0;
               cnt    <= '0;
            end
            ST_SETTLE: begin
               cnt <= cnt + 1'b1;
               if (f_use != f_prev) begin
                  f_prev <= f_use;
                  if (tcnt != 2'd3) tcnt <= tcnt + 1'b1;
               end
            end
            ST_SAMPLE: begin
               if (idx != 3'(SEQ_LEN - 1)) idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_azar.sv
// Self-checking bench for control_azar: behavioural UUT with injectable glitches, W=8 and W=2 instances.
module tb_control_azar;

   localparam int S   = 8;
   localparam int PER = S + 2;
   localparam int NV  = 7;
   localparam int LAT = NV * PER;

   logic       clk = 1'b0;
   logic       reset_n, start;
   logic [3:0] tabla;
   logic [3:0] uut_tt;
   logic       glitch;

   logic       a, b, f, busy, done, pass;
   logic [7:0] err_count, glitch_count;
   logic       a2, b2, f2, busy2, done2, pass2;
   logic [1:0] err2, glitch2;

   assign f  = uut_tt[{a, b}] ^ glitch;
   assign f2 = uut_tt[{a2, b2}] ^ glitch;

   always #5 clk = ~clk;

   control_azar #(.SETTLE(S), .W(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .tabla(tabla), .a(a), .b(b), .f(f),
      .busy(busy), .done(done), .err_count(err_count), .glitch_count(glitch_count), .pass(pass)
   );

   control_azar #(.SETTLE(S), .W(2)) dut_w2 (
      .clk(clk), .reset_n(reset_n), .start(start), .tabla(tabla), .a(a2), .b(b2), .f(f2),
      .busy(busy2), .done(done2), .err_count(err2), .glitch_count(glitch2), .pass(pass2)
   );

   int checks   = 0;
   int failures = 0;

   logic [1:0] seq_ref [NV] = '{2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b00};

   int exp_err, exp_glitch, exp_err2, exp_glitch2;
   int obs_lat, obs_busy, obs_ab_bad;

   // Reference: transitions per vector = output change from previous vector + 2 per injected pulse.
   task automatic model(input logic [3:0] tt, input logic [3:0] tab, input logic [6:0] gm);
      logic [1:0] prev;
      int trans;
      prev = 2'b00;
      exp_err = 0;
      exp_glitch = 0;
      for (int k = 0; k < NV; k++) begin
         trans = ((tt[seq_ref[k]] != tt[prev]) ? 1 : 0) + (gm[k] ? 2 : 0);
         if (tt[seq_ref[k]] != tab[seq_ref[k]]) exp_err++;
         if (trans > 1) exp_glitch++;
         prev = seq_ref[k];
      end
      exp_err2    = (exp_err > 3) ? 3 : exp_err;
      exp_glitch2 = (exp_glitch > 3) ? 3 : exp_glitch;
   endtask

   // Runs one sequence; returns at the negedge after the done cycle (or right after asserting reset).
   task automatic drive_run(input logic [3:0] tt, input logic [3:0] tab, input logic [6:0] gm,
                            input bit extra_start, input int abort_n);
      uut_tt = tt;
      glitch = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tabla = tab;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tabla = ~tab;
      obs_lat = -1;
      obs_busy = 0;
      obs_ab_bad = 0;
      for (int n = 0; n < LAT + 20; n++) begin
         if (busy) obs_busy++;
         if (done && obs_lat < 0) obs_lat = n;
         if (n < LAT && (n % PER) == 2 && {a, b} !== seq_ref[n / PER]) obs_ab_bad++;
         glitch = (n < LAT) && ((n % PER) == 2) && gm[n / PER];
         start  = extra_start && (n == 20 || n == LAT);
         if (n == abort_n) begin
            glitch = 1'b0;
            start = 1'b0;
            reset_n = 1'b0;
            return;
         end
         if (obs_lat >= 0) begin
            @(negedge clk);
            start = 1'b0;
            glitch = 1'b0;
            return;
         end
         @(negedge clk);
      end
      start = 1'b0;
      glitch = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start = 1'b0;
      tabla = 4'h0;
      uut_tt = 4'h0;
      glitch = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({a, b, busy, done, pass} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b need=00000", {a, b, busy, done, pass});
      end
      checks++;
      if (err_count !== 8'd0 || glitch_count !== 8'd0) begin
         failures++;
         $display("FAIL reset_counts got err=%0d glitch=%0d need 0/0", err_count, glitch_count);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle busy got=%b need=0", busy);
      end
   endtask

   task automatic test_ideal();
      drive_run(4'b1010, 4'b1010, 7'b0, 1'b0, -1);
      model(4'b1010, 4'b1010, 7'b0);
      checks++;
      if (obs_lat != LAT) begin
         failures++;
         $display("FAIL ideal_latency got=%0d need=%0d", obs_lat + 1, LAT + 1);
      end
      checks++;
      if (obs_busy != NV * PER) begin
         failures++;
         $display("FAIL ideal_busy_cycles got=%0d need=%0d", obs_busy, NV * PER);
      end
      checks++;
      if (obs_ab_bad != 0) begin
         failures++;
         $display("FAIL ideal_vectors got=%0d bad need=0", obs_ab_bad);
      end
      checks++;
      if (err_count !== 8'(exp_err) || glitch_count !== 8'(exp_glitch) || pass !== 1'b1) begin
         failures++;
         $display("FAIL ideal_result got err=%0d glitch=%0d pass=%b need %0d/%0d/1",
                  err_count, glitch_count, pass, exp_err, exp_glitch);
      end
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse_width got=%b need=0", done);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (pass !== 1'b1 || {a, b} !== 2'b00 || err_count !== 8'd0) begin
         failures++;
         $display("FAIL idle_hold got pass=%b ab=%b err=%0d need 1/00/0", pass, {a, b}, err_count);
      end
   endtask

   task automatic test_tabla_zero();
      drive_run(4'b1010, 4'b0000, 7'b0, 1'b0, -1);
      model(4'b1010, 4'b0000, 7'b0);
      checks++;
      if (err_count !== 8'(exp_err) || glitch_count !== 8'(exp_glitch) || pass !== 1'b0) begin
         failures++;
         $display("FAIL tabla_zero got err=%0d glitch=%0d pass=%b need %0d/%0d/0",
                  err_count, glitch_count, pass, exp_err, exp_glitch);
      end
   endtask

   task automatic test_glitch();
      drive_run(4'b1010, 4'b1010, 7'b0001000, 1'b0, -1);
      model(4'b1010, 4'b1010, 7'b0001000);
      checks++;
      if (err_count !== 8'(exp_err) || glitch_count !== 8'(exp_glitch) || pass !== 1'b0) begin
         failures++;
         $display("FAIL hazard_glitch got err=%0d glitch=%0d pass=%b need %0d/%0d/0",
                  err_count, glitch_count, pass, exp_err, exp_glitch);
      end
   endtask

   task automatic test_saturation();
      drive_run(4'b1010, 4'b1111, 7'b1111111, 1'b0, -1);
      model(4'b1010, 4'b1111, 7'b1111111);
      checks++;
      if (err_count !== 8'(exp_err) || glitch_count !== 8'(exp_glitch)) begin
         failures++;
         $display("FAIL sat_w8 got err=%0d glitch=%0d need %0d/%0d",
                  err_count, glitch_count, exp_err, exp_glitch);
      end
      checks++;
      if (err2 !== 2'(exp_err2) || glitch2 !== 2'(exp_glitch2) || pass2 !== 1'b0) begin
         failures++;
         $display("FAIL sat_w2 got err=%0d glitch=%0d pass=%b need %0d/%0d/0",
                  err2, glitch2, pass2, exp_err2, exp_glitch2);
      end
   endtask

   task automatic test_random();
      logic [3:0] tt, tab;
      logic [6:0] gm;
      for (int r = 0; r < 8; r++) begin
         tt  = 4'($urandom_range(0, 15));
         tab = (r % 2 == 0) ? tt : 4'($urandom_range(0, 15));
         gm  = ($urandom_range(0, 2) == 0) ? 7'b0 : 7'($urandom);
         drive_run(tt, tab, gm, 1'b0, -1);
         model(tt, tab, gm);
         checks++;
         if (err_count !== 8'(exp_err) || glitch_count !== 8'(exp_glitch) ||
             pass !== ((exp_err == 0) && (exp_glitch == 0))) begin
            failures++;
            $display("FAIL random_w8 run=%0d tt=%b tab=%b gm=%b got err=%0d glitch=%0d pass=%b need %0d/%0d",
                     r, tt, tab, gm, err_count, glitch_count, pass, exp_err, exp_glitch);
         end
         checks++;
         if (err2 !== 2'(exp_err2) || glitch2 !== 2'(exp_glitch2)) begin
            failures++;
            $display("FAIL random_w2 run=%0d got err=%0d glitch=%0d need %0d/%0d",
                     r, err2, glitch2, exp_err2, exp_glitch2);
         end
      end
   endtask

   task automatic test_back_to_back();
      drive_run(4'b1010, 4'b1010, 7'b0, 1'b1, -1);
      model(4'b1010, 4'b1010, 7'b0);
      checks++;
      if (obs_lat != LAT || err_count !== 8'(exp_err) || glitch_count !== 8'(exp_glitch) || pass !== 1'b1) begin
         failures++;
         $display("FAIL start_ignored got lat=%0d err=%0d glitch=%0d pass=%b need %0d/%0d/%0d/1",
                  obs_lat + 1, err_count, glitch_count, pass, LAT + 1, exp_err, exp_glitch);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL start_in_done busy got=%b need=0", busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] tt;
      logic [6:0] gm;
      drive_run(4'b1010, 4'b0000, 7'b0001000, 1'b0, 3 * PER + 5);
      #1;
      checks++;
      if ({a, b, busy, done, pass, a2, b2, busy2} !== 8'b0 || err_count !== 8'd0 ||
          glitch_count !== 8'd0 || err2 !== 2'd0) begin
         failures++;
         $display("FAIL mid_reset got ab=%b busy=%b done=%b pass=%b err=%0d glitch=%0d need all 0",
                  {a, b}, busy, done, pass, err_count, glitch_count);
      end
      @(negedge clk);
      reset_n = 1'b1;
      tt = 4'($urandom_range(0, 15));
      gm = 7'($urandom);
      drive_run(tt, 4'b1010, gm, 1'b0, -1);
      model(tt, 4'b1010, gm);
      checks++;
      if (obs_lat != LAT || err_count !== 8'(exp_err) || glitch_count !== 8'(exp_glitch)) begin
         failures++;
         $display("FAIL after_reset_run got lat=%0d err=%0d glitch=%0d need %0d/%0d/%0d",
                  obs_lat + 1, err_count, glitch_count, LAT + 1, exp_err, exp_glitch);
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_tabla_zero();
      test_glitch();
      test_saturation();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
